// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register driving a 2-entry instruction queue with redirect flush.
// Latency: a word fetched at edge N is visible on inst at cycle N+1. Backpressure: inst_ready low stalls PC once the queue is full.
// Optional FETCH_BOUND_EN: freezes fetch and raises sticky fetch_err when PC[31:8] != 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        fetch_err
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    entry_t      q_q [QDEPTH];
    entry_t      q_d [QDEPTH];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;

    logic   full;
    logic   push;
    logic   pop;
    logic   halt;
    entry_t head;

`ifdef FETCH_BOUND_EN
    logic err_q, err_d;

    assign halt      = (pc_q[31:8] != 24'd0);
    assign err_d     = err_q | halt;
    assign fetch_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign halt      = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign imem_addr  = pc_q;
    assign full       = (count_q == 2'd2);
    assign inst_valid = (count_q != 2'd0);
    assign head       = q_q[rd_ptr_q];
    assign pop        = inst_valid && inst_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign push       = !redirect_valid && !halt && (!full || pop);

    assign inst     = inst_valid ? head.word : 32'd0;
    assign inst_pc  = inst_valid ? head.pc : 32'd0;
    assign inst_pc4 = inst_valid ? (head.pc + 32'd4) : 32'd0;

    always_comb begin
        q_d      = q_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;

        if (redirect_valid) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
            pc_d     = {redirect_pc[31:2], 2'b00};
        end else begin
            if (push) begin
                q_d[wr_ptr_q] = '{pc: pc_q, word: imem_data};
                wr_ptr_d      = ~wr_ptr_q;
                pc_d          = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            pc_q     <= RESET_PC_ALIGNED;
        end else begin
            q_q      <= q_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

endmodule
